// File: rtl/hud_text_ctrl.sv
// HUD text RAM write sequencer: converts the score to three ASCII digits and
// the lives count to one ASCII digit, serialising both onto one write port.
module hud_text_ctrl #(
    parameter int unsigned SCORE_ADDR = 7,
    parameter int unsigned LIVES_ADDR = 32,
    parameter int unsigned SCORE_W    = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [SCORE_W-1:0] score,
    input  logic [3:0]         lives,
    input  logic               score_req,
    input  logic               lives_req,
    output logic               busy,
    output logic               done,
    output logic               we,
    output logic [7:0]         write_address,
    output logic [7:0]         write_data
);

    localparam logic [SCORE_W-1:0] MaxScore = SCORE_W'(999);
    localparam logic [SCORE_W-1:0] Hundred  = SCORE_W'(100);
    localparam logic [SCORE_W-1:0] Ten      = SCORE_W'(10);
    localparam logic [7:0]         AddrH    = 8'(SCORE_ADDR);
    localparam logic [7:0]         AddrT    = 8'(SCORE_ADDR + 1);
    localparam logic [7:0]         AddrO    = 8'(SCORE_ADDR + 2);
    localparam logic [7:0]         AddrL    = 8'(LIVES_ADDR);
    localparam logic [7:0]         AsciiZero = 8'h30;

    typedef enum logic [2:0] {
        StIdle, StConvH, StConvT, StWrH, StWrT, StWrO, StWrL, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] rem_q, rem_d;
    logic [3:0]         h_q, h_d;
    logic [3:0]         t_q, t_d;
    logic [3:0]         lv_q, lv_d;
    logic               pending_s_q, pending_s_d;
    logic               pending_l_q, pending_l_d;
    logic               want_s, want_l, accept_s, accept_l;

    // State, datapath and pending-flag registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            h_q         <= '0;
            t_q         <= '0;
            lv_q        <= '0;
            pending_s_q <= 1'b0;
            pending_l_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            h_q         <= h_d;
            t_q         <= t_d;
            lv_q        <= lv_d;
            pending_s_q <= pending_s_d;
            pending_l_q <= pending_l_d;
        end
    end

    // Arbitration, BCD conversion by repeated subtraction, and sequencing
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        h_d      = h_q;
        t_d      = t_q;
        lv_d     = lv_q;
        want_s   = score_req | pending_s_q;
        want_l   = lives_req | pending_l_q;
        // Score wins when both are waiting; lives stays pending
        accept_s = (state_q == StIdle) && want_s;
        accept_l = (state_q == StIdle) && !want_s && want_l;
        pending_s_d = accept_s ? 1'b0 : want_s;
        pending_l_d = accept_l ? 1'b0 : want_l;

        unique case (state_q)
            StIdle: begin
                if (accept_s) begin
                    rem_d   = (score > MaxScore) ? MaxScore : score;
                    h_d     = '0;
                    t_d     = '0;
                    state_d = StConvH;
                end else if (accept_l) begin
                    lv_d    = (lives > 4'd9) ? 4'd9 : lives;
                    state_d = StWrL;
                end
            end
            StConvH: begin
                if (rem_q >= Hundred) begin
                    rem_d = rem_q - Hundred;
                    h_d   = h_q + 4'd1;
                end else begin
                    state_d = StConvT;
                end
            end
            StConvT: begin
                if (rem_q >= Ten) begin
                    rem_d = rem_q - Ten;
                    t_d   = t_q + 4'd1;
                end else begin
                    state_d = StWrH;
                end
            end
            StWrH:   state_d = StWrT;
            StWrT:   state_d = StWrO;
            StWrO:   state_d = StDone;
            StWrL:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from registered state and digits
    always_comb begin
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        we            = 1'b0;
        write_address = '0;
        write_data    = '0;
        unique case (state_q)
            StWrH: begin
                we            = 1'b1;
                write_address = AddrH;
                write_data    = AsciiZero + {4'h0, h_q};
            end
            StWrT: begin
                we            = 1'b1;
                write_address = AddrT;
                write_data    = AsciiZero + {4'h0, t_q};
            end
            StWrO: begin
                we            = 1'b1;
                write_address = AddrO;
                // rem is below ten once conversion finishes
                write_data    = AsciiZero + {4'h0, rem_q[3:0]};
            end
            StWrL: begin
                we            = 1'b1;
                write_address = AddrL;
                write_data    = AsciiZero + {4'h0, lv_q};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/hud_text_ctrl.md
Name: hud_text_ctrl

Overview:
- Sequencer that owns the write port of the HUD text RAM.
- Converts the binary score into three ASCII decimal digits and writes them to the score digit cells; writes the lives count as one ASCII digit to the lives cell.
- Score and lives update requests are arbitrated and serialized onto the single write port.
- Sits between game logic (score/lives counters) and the text RAM read by the VGA text renderer.

Parameters:
- SCORE_ADDR, 7, RAM address of hundreds digit; tens at +1, ones at +2
- LIVES_ADDR, 32, RAM address of lives digit
- SCORE_W, 10, width of score input

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- score  in  SCORE_W  binary score from game logic
- lives  in  4  binary lives count
- score_req  in  1  request to rewrite score digits; level or pulse
- lives_req  in  1  request to rewrite lives digit; level or pulse
- busy  out  1  high while a job is in progress (any state except IDLE)
- done  out  1  one-cycle pulse in DONE state at the end of each job
- we  out  1  RAM write enable
- write_address  out  8  RAM write address
- write_data  out  8  RAM write data (ASCII)

Behaviour:
- Reset (async) forces the following immediately:
  - state = IDLE; pending_s = pending_l = 0.
  - busy, done and we = 0; write_address and write_data = 0.
  - Writes already completed are not undone.
- Outputs are Moore outputs, decoded from registered state and datapath only.
- States: IDLE, CONV_H, CONV_T, WR_H, WR_T, WR_O, WR_L, DONE.
- Pending flags:
  - A request high at an edge where it is not accepted sets its pending flag.
  - Repeated requests coalesce into the one flag.
  - The flag clears on acceptance.
- Acceptance is evaluated only in IDLE. Score (score_req | pending_s) has priority over lives.
- Score job, accepted at edge N:
  - Captures rem = min(score, 999); h = 0; t = 0.
  - Next state is CONV_H.
  - The score value is sampled at acceptance, not at request time.
- CONV_H, one step per cycle:
  - If rem >= 100: rem -= 100, h += 1, stay in CONV_H.
  - Else go to CONV_T.
- CONV_T: same procedure with 10 and t; on exit go to WR_H. The final rem is the ones digit o.
- Score write sequence:
  - WR_H: we=1, address SCORE_ADDR, data 0x30+h.
  - WR_T: we=1, address SCORE_ADDR+1, data 0x30+t.
  - WR_O: we=1, address SCORE_ADDR+2, data 0x30+o.
  - Then DONE.
- Score latency: DONE is occupied h+t+6 cycles after the acceptance edge. Maximum is 24 cycles, at 999.
- Lives job:
  - On acceptance, captures L = min(lives, 9) and goes to WR_L.
  - WR_L: we=1, address LIVES_ADDR, data 0x30+L. Then DONE.
  - DONE is reached 2 cycles after acceptance.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
  - Pending work is accepted from IDLE on the following edge, so there is at least one idle cycle between jobs.
- we is high for exactly one cycle per digit. No other cycle asserts we.
- Arithmetic:
  - h, t and o are 4-bit.
  - rem is SCORE_W bits wide.
  - write_address is 8-bit; SCORE_ADDR+2 must not exceed 255.
- Inputs changing mid-job have no effect on that job. A request arriving mid-job sets its pending flag.
- Simultaneous score_req and lives_req in IDLE: the score job runs first, pending_l is set, and the lives job follows.

Test Plan:
- Reset asserted mid-WR_T with score=345 -> we=0 immediately; state IDLE; only address 7 was written (0x33); no done pulse.
- score=0, pulse score_req -> writes (7,0x30),(8,0x30),(9,0x30) on consecutive cycles; done 6 cycles after acceptance.
- score=1023, pulse score_req -> clamped; writes (7,0x39),(8,0x39),(9,0x39); done 24 cycles after acceptance.
- score=207 and lives=2, both requests in the same cycle -> score writes (7,0x32),(8,0x30),(9,0x37), done pulse, one idle cycle, then (32,0x32), done pulse.
- lives=12, pulse lives_req -> single write (32,0x39); busy high for 2 cycles.
- During a score job, pulse lives_req twice and change score -> the running job writes the captured score; exactly one lives job follows; no extra score job.
